rgb_pwm_decoder: RTL and testbench

//  Receive-side counterpart of the RGB LED PWM driver. Samples the three PWM lines (R,G,B) on clk and

---
 rtl/rgb_pwm_pkg.sv | 14 +
 rtl/rgb_pwm_chan.sv | 77 +++++++
 rtl/rgb_pwm_decoder.sv | 114 +++++++++++
 tb/tb_rgb_pwm_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM decoder.
// Used by rgb_pwm_chan and rgb_pwm_decoder.
package rgb_pwm_pkg;

    typedef enum logic {S_IDLE, S_MEASURE} pwm_dec_state_t;

    localparam int unsigned CH_R   = 0;
    localparam int unsigned CH_G   = 1;
    localparam int unsigned CH_B   = 2;
    localparam int unsigned NUM_CH = 3;

    localparam int unsigned PWM_WIN_12MHZ_1MS = 12000;

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: 2-flop synchronizer, window high-time counter and latched result.
// RGB_PWM_EDGE_CNT_EN adds a rising-edge counter latched alongside the duty count.
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_pwm,
    input  logic             i_active,
    input  logic             i_win_end,
`ifdef RGB_PWM_EDGE_CNT_EN
    output logic [CNT_W-1:0] o_edges,
`endif
    output logic [CNT_W-1:0] o_duty
);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] w_hi_sum;

    // Includes the current cycle's bit so the window-end cycle is counted too.
    assign w_hi_sum = r_hi + CNT_W'(r_sync2);
    assign o_duty   = r_duty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hi    <= '0;
            r_duty  <= '0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
            if (!i_active || i_win_end) begin
                r_hi <= '0;
            end else begin
                r_hi <= w_hi_sum;
            end
            if (i_win_end) begin
                r_duty <= w_hi_sum;
            end
        end
    end

`ifdef RGB_PWM_EDGE_CNT_EN
    logic             r_sync_prev;
    logic [CNT_W-1:0] r_edge_cnt;
    logic [CNT_W-1:0] r_edges;
    logic [CNT_W-1:0] w_edge_sum;

    assign w_edge_sum = r_edge_cnt + CNT_W'(r_sync2 & ~r_sync_prev);
    assign o_edges    = r_edges;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_prev <= 1'b0;
            r_edge_cnt  <= '0;
            r_edges     <= '0;
        end else begin
            r_sync_prev <= r_sync2;
            if (!i_active || i_win_end) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= w_edge_sum;
            end
            if (i_win_end) begin
                r_edges <= w_edge_sum;
            end
        end
    end
`endif

endmodule

// File: rtl/rgb_pwm_decoder.sv
// Measures high-time of three PWM lines over fixed windows; valid/ready sample output.
// Define RGB_PWM_EDGE_CNT_EN to add per-channel rising-edge counts (edges_r/g/b).
module rgb_pwm_decoder
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = PWM_WIN_12MHZ_1MS,
    parameter int unsigned CNT_W         = $clog2(PERIOD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_r,
    input  logic             pwm_g,
    input  logic             pwm_b,
    output logic [CNT_W-1:0] duty_r,
    output logic [CNT_W-1:0] duty_g,
    output logic [CNT_W-1:0] duty_b,
`ifdef RGB_PWM_EDGE_CNT_EN
    output logic [CNT_W-1:0] edges_r,
    output logic [CNT_W-1:0] edges_g,
    output logic [CNT_W-1:0] edges_b,
`endif
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    pwm_dec_state_t   r_state;
    pwm_dec_state_t   w_state_next;
    logic [CNT_W-1:0] r_win_cnt;
    logic             r_valid;
    logic             r_overrun;
    logic             w_active;
    logic             w_win_end;
    logic             w_consume;
    logic [NUM_CH-1:0] w_pwm;
    logic [CNT_W-1:0] w_duty [NUM_CH];
`ifdef RGB_PWM_EDGE_CNT_EN
    logic [CNT_W-1:0] w_edges [NUM_CH];
`endif

    // Dropping enable discards the current window on the same cycle.
    assign w_active  = (r_state == S_MEASURE) && enable;
    assign w_win_end = w_active && (r_win_cnt == CNT_W'(PERIOD_CYCLES - 1));
    assign w_consume = r_valid && sample_ready;
    assign w_pwm     = {pwm_b, pwm_g, pwm_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (enable)  w_state_next = S_MEASURE;
            S_MEASURE: if (!enable) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (!w_active || w_win_end) begin
                r_win_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + CNT_W'(1);
            end
            // A coincident consume makes room for the new sample, so no overrun.
            if (w_win_end) begin
                r_valid   <= 1'b1;
                r_overrun <= r_valid && !sample_ready;
            end else if (w_consume) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        rgb_pwm_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_pwm     (w_pwm[g]),
            .i_active  (w_active),
            .i_win_end (w_win_end),
`ifdef RGB_PWM_EDGE_CNT_EN
            .o_edges   (w_edges[g]),
`endif
            .o_duty    (w_duty[g])
        );
    end

    assign duty_r       = w_duty[CH_R];
    assign duty_g       = w_duty[CH_G];
    assign duty_b       = w_duty[CH_B];
`ifdef RGB_PWM_EDGE_CNT_EN
    assign edges_r      = w_edges[CH_R];
    assign edges_g      = w_edges[CH_G];
    assign edges_b      = w_edges[CH_B];
`endif
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// Directed bench for rgb_pwm_decoder with a 100-cycle window.
// Edge-count checks are included when RGB_PWM_EDGE_CNT_EN is defined.
`timescale 1ns/1ps
module tb_rgb_pwm_decoder;

    localparam int unsigned PERIOD_CYCLES = 100;
    localparam int unsigned CNT_W         = $clog2(PERIOD_CYCLES + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             pwm_r;
    logic             pwm_g;
    logic             pwm_b;
    logic             sample_ready;
    logic [CNT_W-1:0] duty_r;
    logic [CNT_W-1:0] duty_g;
    logic [CNT_W-1:0] duty_b;
    logic             sample_valid;
    logic             overrun;
`ifdef RGB_PWM_EDGE_CNT_EN
    logic [CNT_W-1:0] edges_r;
    logic [CNT_W-1:0] edges_g;
    logic [CNT_W-1:0] edges_b;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ph          = 0;
    bit gen_g       = 1'b0;

    always #41.667 clk = ~clk;

    rgb_pwm_decoder #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .pwm_r        (pwm_r),
        .pwm_g        (pwm_g),
        .pwm_b        (pwm_b),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
`ifdef RGB_PWM_EDGE_CNT_EN
        .edges_r      (edges_r),
        .edges_g      (edges_g),
        .edges_b      (edges_b),
`endif
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; inputs change 1 ns after the edge. pwm_g optionally runs 5 high / 20.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (gen_g) begin
            pwm_g = (ph < 5);
            ph    = (ph + 1) % 20;
        end
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_ready = 1'b1;
        pwm_r = 1'b1; pwm_g = 1'b0; pwm_b = 1'b0;
        repeat (3) tick();
        check("rst_duty_r", 32'(duty_r), 0);
        check("rst_duty_g", 32'(duty_g), 0);
        check("rst_duty_b", 32'(duty_b), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
`ifdef RGB_PWM_EDGE_CNT_EN
        check("rst_edges_r", 32'(edges_r), 0);
`endif
        rst_n = 1'b1;
        repeat (4) tick();

        // Window k measures cycles 100k-99..100k and is visible from cycle 100k+1.
        enable = 1'b1; cyc = 0;
        tick_to(100); check("t1_no_early_valid", 32'(sample_valid), 0);
        tick_to(101);
        check("t1_duty_r", 32'(duty_r), 100);
        check("t1_duty_g", 32'(duty_g), 0);
        check("t1_duty_b", 32'(duty_b), 0);
        check("t1_valid", 32'(sample_valid), 1);
        check("t1_overrun", 32'(overrun), 0);
`ifdef RGB_PWM_EDGE_CNT_EN
        check("t1_edges_r", 32'(edges_r), 0);
`endif
        tick_to(102);
        check("t1_consumed", 32'(sample_valid), 0);
        check("t1_duty_hold", 32'(duty_r), 100);

        pwm_r = 1'b0; gen_g = 1'b1;
        tick_to(301);
        check("t2_duty_r", 32'(duty_r), 0);
        check("t2_duty_g", 32'(duty_g), 25);
        check("t2_duty_b", 32'(duty_b), 0);
`ifdef RGB_PWM_EDGE_CNT_EN
        check("t2_edges_g", 32'(edges_g), 5);
        check("t2_edges_r", 32'(edges_r), 0);
`endif
        tick_to(401);
        check("t2_duty_g_again", 32'(duty_g), 25);
`ifdef RGB_PWM_EDGE_CNT_EN
        check("t2_edges_g_again", 32'(edges_g), 5);
`endif

        tick_to(402);
        check("t3_start_idle", 32'(sample_valid), 0);
        gen_g = 1'b0; pwm_g = 1'b0; sample_ready = 1'b0;
        tick_to(500); check("t3_valid_before", 32'(sample_valid), 0);
        tick_to(501);
        check("t3_valid_w1", 32'(sample_valid), 1);
        check("t3_ovr_w1", 32'(overrun), 0);
        tick_to(600); check("t3_ovr_before_w2", 32'(overrun), 0);
        tick_to(601);
        check("t3_valid_w2", 32'(sample_valid), 1);
        check("t3_ovr_w2", 32'(overrun), 1);
        tick_to(652);
        check("t3_ovr_hold", 32'(overrun), 1);
        sample_ready = 1'b1;
        tick_to(653);
        check("t3_valid_cleared", 32'(sample_valid), 0);
        check("t3_ovr_cleared", 32'(overrun), 0);
        sample_ready = 1'b0;

        // ready pulsed only on window-end cycles so each consume coincides with a load.
        tick_to(701); check("t4_first_valid", 32'(sample_valid), 1);
        for (int w = 0; w < 5; w++) begin
            tick_to(750 + 100 * w);
            check("t4_mid_valid", 32'(sample_valid), 1);
            tick_to(800 + 100 * w);
            sample_ready = 1'b1;
            tick_to(801 + 100 * w);
            check("t4_valid", 32'(sample_valid), 1);
            check("t4_overrun", 32'(overrun), 0);
            sample_ready = 1'b0;
        end
        sample_ready = 1'b1;
        tick_to(1202); check("t4_drain", 32'(sample_valid), 0);

        tick_to(1241);
        enable = 1'b0;
        tick_to(1251);
        check("t5_idle_valid", 32'(sample_valid), 0);
        enable = 1'b1; pwm_b = 1'b1;
        tick_to(1301); check("t5_no_partial", 32'(sample_valid), 0);
        tick_to(1351); check("t5_not_yet", 32'(sample_valid), 0);
        tick_to(1352);
        check("t5_valid", 32'(sample_valid), 1);
        // First window cycle still sees the pre-enable synchronizer output.
        check("t5_duty_b", 32'(duty_b), 99);
        check("t5_duty_r", 32'(duty_r), 0);
        check("t5_duty_g", 32'(duty_g), 0);
`ifdef RGB_PWM_EDGE_CNT_EN
        check("t5_edges_b", 32'(edges_b), 1);
`endif
        sample_ready = 1'b0;

        tick_to(1411);
        check("t6_pre_valid", 32'(sample_valid), 1);
        check("t6_pre_duty_b", 32'(duty_b), 99);
        tick_to(1412);
        rst_n = 1'b0;
        #1;
        check("t6_rst_duty_b", 32'(duty_b), 0);
        check("t6_rst_valid", 32'(sample_valid), 0);
        check("t6_rst_overrun", 32'(overrun), 0);
`ifdef RGB_PWM_EDGE_CNT_EN
        check("t6_rst_edges_b", 32'(edges_b), 0);
`endif
        tick_to(1413);
        rst_n = 1'b1; sample_ready = 1'b1;
        tick_to(1513); check("t6_not_yet", 32'(sample_valid), 0);
        tick_to(1514);
        check("t6_valid", 32'(sample_valid), 1);
        check("t6_duty_b", 32'(duty_b), 99);
        check("t6_overrun", 32'(overrun), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
